// File: rtl/irq_req_latch.sv
// irq_req_latch
// Eight-channel request capture stage. Rising edges (or levels) on req are
// latched into a pending register, filtered by a per-channel mask, and the
// highest eligible channel is offered as a registered 3-bit code over a
// valid/ready handshake. A sticky overflow flag records requests that arrive
// for a channel that is already pending.

module irq_req_latch #(
   parameter bit EDGE_MODE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       mask_wr,
   input  logic [7:0] mask_in,
   output logic [2:0] code,
   output logic       valid,
   input  logic       ready,
   output logic [7:0] pending,
   output logic       ovf,
   input  logic       ovf_clr
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t     state_r;
   logic [7:0] req_q_r;
   logic [7:0] pending_r;
   logic [7:0] mask_r;
   logic [2:0] code_r;
   logic       valid_r;
   logic       ovf_r;

   logic [7:0] raw_set_s;
   logic [7:0] set_vec_s;
   logic [7:0] clr_vec_s;
   logic [7:0] pending_next_s;
   logic [7:0] eligible_s;
   logic       accept_s;
   logic       ovf_hit_s;

   // Index of the most significant set bit; returns 0 for an all-zero vector.
   function automatic logic [2:0] highest_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Set/clear vectors, next pending value, eligibility and overflow detection.
   always_comb begin
      raw_set_s      = 8'h00;
      set_vec_s      = 8'h00;
      clr_vec_s      = 8'h00;
      pending_next_s = 8'h00;
      eligible_s     = 8'h00;
      accept_s       = 1'b0;
      ovf_hit_s      = 1'b0;

      if (EDGE_MODE) begin
         raw_set_s = req & ~req_q_r;
      end else begin
         raw_set_s = req;
      end

      // Masked events are dropped here, not deferred until unmask.
      set_vec_s = raw_set_s & ~mask_r;
      accept_s  = valid_r & ready;

      if (accept_s) begin
         clr_vec_s = 8'b0000_0001 << code_r;
      end else begin
         clr_vec_s = 8'h00;
      end

      // A set in the same cycle as the clear of that bit keeps it pending.
      pending_next_s = (pending_r & ~clr_vec_s) | set_vec_s;
      eligible_s     = pending_r & ~mask_r;

      if (EDGE_MODE) begin
         ovf_hit_s = |(set_vec_s & pending_r & ~clr_vec_s);
      end else begin
         ovf_hit_s = 1'b0;
      end
   end

   // Request history, pending, mask and sticky overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q_r   <= 8'h00;
         pending_r <= 8'h00;
         mask_r    <= 8'h00;
         ovf_r     <= 1'b0;
      end else begin
         req_q_r   <= req;
         pending_r <= pending_next_s;
         if (mask_wr) begin
            mask_r <= mask_in;
         end else begin
            mask_r <= mask_r;
         end
         // A new overflow takes precedence over a clear in the same cycle.
         if (ovf_hit_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

   // Offer FSM: code is captured only when leaving IDLE and held until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         code_r  <= 3'd0;
         valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (|eligible_s) begin
                  code_r  <= highest_idx(eligible_s);
                  valid_r <= 1'b1;
                  state_r <= OFFER;
               end else begin
                  code_r  <= code_r;
                  valid_r <= 1'b0;
                  state_r <= IDLE;
               end
            end
            OFFER: begin
               if (ready) begin
                  valid_r <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  valid_r <= 1'b1;
                  state_r <= OFFER;
               end
               code_r <= code_r;
            end
            default: begin
               code_r  <= 3'd0;
               valid_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign code    = code_r;
   assign valid   = valid_r;
   assign pending = pending_r;
   assign ovf     = ovf_r;

endmodule

// File: doc/irq_req_latch.md
# irq_req_latch

Eight-channel request capture and hand-off stage that sits directly upstream of the 8-to-3 priority encoding path. It latches rising edges on raw request lines into a pending register and applies a per-channel mask. It offers the highest-index eligible channel as a registered 3-bit code over a valid/ready handshake, and clears that channel's pending bit when the consumer accepts it. A sticky overflow flag records requests that arrived for a channel already pending.

## Interface
- EDGE_MODE, default 1: 1 = a channel is set on a rising edge of its req bit; 0 = set while the req bit is high (level mode, overflow detection disabled).
- clk  input  1  the single clock; all registers update on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req  input  8  raw request lines; bit i = channel i; must be synchronous to clk.
- mask_wr  input  1  when 1, mask_in is loaded into the mask register at the clock edge.
- mask_in  input  8  new mask value; bit = 1 disables that channel.
- code  output  3  offered channel index; stable while valid = 1.
- valid  output  1  code is offered.
- ready  input  1  consumer accepts when valid & ready.
- pending  output  8  current pending register.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  clears ovf.

## Operation
- Registers: req_q[7:0], pending[7:0], mask[7:0], code[2:0], ovf, and a 2-state FSM (IDLE, OFFER).
- Raw set vector:
  - EDGE_MODE = 1: req & ~req_q.
  - EDGE_MODE = 0: req.
- set_vec = raw set vector & ~mask. Masked events are discarded, not deferred.
- clr_vec = one-hot(code) when valid & ready, else 0.
- pending_next = (pending & ~clr_vec) | set_vec.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Eligible vector = pending & ~mask.
  - Masking a channel that is already pending leaves its bit pending but ineligible.
  - Unmasking that channel makes it eligible again.
- FSM:
  - IDLE: valid = 0. If eligible != 0, load code with the highest set index of eligible and go to OFFER.
  - OFFER: valid = 1 and code is held. On valid & ready, clear pending[code] and go to IDLE.
  - There is no retraction. Neither a new higher-priority request nor a mask write changes code or drops valid before acceptance.
- Overflow (EDGE_MODE = 1 only): set ovf when any set_vec bit hits a pending bit that is not being cleared in the same cycle.
  - ovf_clr clears ovf.
  - If a new overflow and ovf_clr occur in the same cycle, set wins.
- mask_wr takes effect at the clock edge. The same cycle's set_vec uses the old mask.

## Timing
- Reset (async, immediate): req_q = 0, pending = 0, mask = 0 (all channels enabled), code = 0, valid = 0, ovf = 0, FSM = IDLE.
  - Reset mid-OFFER drops valid immediately and loses the offer.
  - A req bit held high across reset release is treated as a rising edge at the first clock edge, because req_q is 0.
- Request latency: req[i] first sampled high at edge k gives pending[i] = 1 after edge k, then valid = 1 with code = i after edge k+1, provided i is the highest eligible channel.
- Acceptance: valid & ready at edge m gives valid = 0 and the pending bit cleared after edge m. The next offer appears no earlier than after edge m+1.
- Throughput is at most 1 code per 2 cycles. IDLE always lasts at least one cycle.
- code may change only on the IDLE-to-OFFER transition.

## Test plan
- Single request: req = 8'h20 for one cycle, ready = 1 → pending = 8'h20 after 1 edge; valid = 1 with code = 3'b101 after 2 edges; after acceptance, valid = 0 and pending = 0.
- Priority order: req = 8'b1001_0010 in one cycle, ready held at 1 → codes 111, 100, 001 appear on three valid pulses, each separated by one idle cycle; pending ends at 0.
- Masking: write mask = 8'h80, then pulse req = 8'h84 → only code = 3'b010 is offered and pending[7] stays 0. Write mask = 0 afterwards → no further offer.
- Backpressure: offer code = 3'b011 with ready = 0 for 5 cycles; pulse req[6] during the stall → code stays 011 and valid stays 1. After ready = 1, code 110 is offered after one idle cycle.
- Overflow: pulse req[1] twice while its offer is stalled → ovf = 1 and pending[1] stays 1. Pulse ovf_clr → ovf = 0. Pulse ovf_clr in the same cycle as a new overflow → ovf stays 1.
- Reset mid-offer: assert rst_n = 0 while valid = 1 and pending = 8'h0C → valid, pending, code and ovf go to 0 immediately, without waiting for a clock edge.
